scroll_compositor: RTL

SCROLL_COMPOSITOR -- requirements
Module: scroll_compositor

---
 rtl/display_pkg.sv | 18 +
 rtl/sprite_hit.sv | 40 ++++
 rtl/scroll_compositor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared colour types and constants for the display pipeline.
package display_pkg;
  typedef logic [11:0] rgb_t;

  localparam rgb_t KEY_COLOR_DEF = 12'hA0A;
  localparam rgb_t BLACK         = 12'h000;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  function automatic logic is_opaque(input rgb_t c, input rgb_t key);
    return c != key;
  endfunction
endpackage

// File: rtl/sprite_hit.sv
// One sprite channel: half-open window test and sprite ROM address, registered
// so hit and address leave together in pipeline stage 0.
module sprite_hit #(
  parameter int PIX_W = 10,
  parameter int SPR_W = 14,
  parameter int SPR_H = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  input  logic [PIX_W-1:0] hor_pix,
  input  logic [PIX_W-1:0] ver_pix,
  output logic             hit,
  output logic [AW-1:0]    addr
);
  logic [PIX_W:0]   x_end, y_end;
  logic [PIX_W-1:0] dx, dy;
  logic             in_win;

  // One extra bit so sprites near the counter limit do not wrap their window
  assign x_end  = {1'b0, x} + (PIX_W+1)'(SPR_W);
  assign y_end  = {1'b0, y} + (PIX_W+1)'(SPR_H);
  assign dx     = hor_pix - x;
  assign dy     = ver_pix - y;
  assign in_win = en && (hor_pix >= x) && ({1'b0, hor_pix} < x_end)
                     && (ver_pix >= y) && ({1'b0, ver_pix} < y_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit  <= 1'b0;
      addr <= '0;
    end else begin
      hit  <= in_win;
      addr <= AW'(dx) + AW'(dy) * AW'(SPR_W);
    end
  end
endmodule

// File: rtl/scroll_compositor.sv
// Scrolling background plus prioritised keyed sprites, 3-cycle pixel pipeline.
// Define SCROLL_COMPOSITOR_COLLISION_EN to build sticky sprite-0 collision flags.
module scroll_compositor
  import display_pkg::*;
#(
  parameter int   PIX_W       = 10,
  parameter int   NUM_SPRITES = 2,
  parameter int   SPR_W       = 14,
  parameter int   SPR_H       = 16,
  parameter int   BG_W        = 160,
  parameter int   BG_H        = 240,
  parameter int   BG_X        = 200,
  parameter int   BG_Y        = 150,
  parameter rgb_t KEY_COLOR   = KEY_COLOR_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [PIX_W-1:0]                             hor_pix,
  input  logic [PIX_W-1:0]                             ver_pix,
  input  logic                                         frame_tick,
  input  logic                                         scroll_en,
  input  logic                                         scroll_dir,
  input  logic [3:0]                                   scroll_div,
  input  logic [NUM_SPRITES-1:0]                       spr_en,
  input  logic [NUM_SPRITES*PIX_W-1:0]                 spr_x,
  input  logic [NUM_SPRITES*PIX_W-1:0]                 spr_y,
  output logic [$clog2(BG_W*BG_H)-1:0]                 bg_addr,
  input  logic [11:0]                                  bg_data,
  output logic [NUM_SPRITES*$clog2(SPR_W*SPR_H)-1:0]   spr_addr,
  input  logic [NUM_SPRITES*12-1:0]                    spr_data,
  input  logic                                         clr_collide,
  output logic [NUM_SPRITES-1:0]                       collide,
  output logic [11:0]                                  pix_rgb
);
  localparam int BG_AW  = $clog2(BG_W*BG_H);
  localparam int SPR_AW = $clog2(SPR_W*SPR_H);
  localparam int OFF_W  = $clog2(BG_H);
  localparam int STAGES = 2;

  logic [NUM_SPRITES-1:0]                  en_sh;
  logic [NUM_SPRITES-1:0][PIX_W-1:0]       x_sh, y_sh;
  logic [3:0]                              div_cnt;
  logic [OFF_W-1:0]                        scroll_off;
  logic [NUM_SPRITES-1:0]                  hit0, hit1;
  logic [NUM_SPRITES-1:0][SPR_AW-1:0]      spr_addr_a;
  rgb_t [NUM_SPRITES-1:0]                  sdata;
  logic                                    bg_win, bg_win0, bg_win1;
  logic [PIX_W-1:0]                        dx, dy;
  logic [OFF_W:0]                          dy_o, row, diff, sum;
  logic [STAGES:1]                         vld_q;
  logic [STAGES:0]                         vld_pipe;
  rgb_t                                    pix_nxt;
  logic                                    found;

  assign sdata    = spr_data;
  assign spr_addr = spr_addr_a;
  assign vld_pipe = {vld_q, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh <= '0;
      x_sh  <= '0;
      y_sh  <= '0;
    end else if (frame_tick) begin
      en_sh <= spr_en;
      x_sh  <= spr_x;
      y_sh  <= spr_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      scroll_off <= '0;
    end else if (frame_tick && scroll_en) begin
      if (div_cnt == scroll_div) begin
        div_cnt    <= '0;
        scroll_off <= (scroll_off == OFF_W'(BG_H-1)) ? '0 : scroll_off + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Row wrap uses one conditional add/subtract; both operands are < BG_H
  assign dx     = hor_pix - PIX_W'(BG_X);
  assign dy     = ver_pix - PIX_W'(BG_Y);
  assign dy_o   = (OFF_W+1)'(dy);
  assign diff   = dy_o - {1'b0, scroll_off};
  assign sum    = dy_o + {1'b0, scroll_off};
  assign row    = scroll_dir ? ((sum >= (OFF_W+1)'(BG_H)) ? sum - (OFF_W+1)'(BG_H) : sum)
                             : ((dy_o < {1'b0, scroll_off}) ? diff + (OFF_W+1)'(BG_H) : diff);
  assign bg_win = ({1'b0, hor_pix} >= (PIX_W+1)'(BG_X)) && ({1'b0, hor_pix} < (PIX_W+1)'(BG_X+BG_W))
               && ({1'b0, ver_pix} >= (PIX_W+1)'(BG_Y)) && ({1'b0, ver_pix} < (PIX_W+1)'(BG_Y+BG_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_addr <= '0;
      bg_win0 <= 1'b0;
      bg_win1 <= 1'b0;
      hit1    <= '0;
      vld_q   <= '0;
    end else begin
      bg_addr <= BG_AW'(dx) + BG_AW'(row) * BG_AW'(BG_W);
      bg_win0 <= bg_win;
      bg_win1 <= bg_win0;
      hit1    <= hit0;
      vld_q   <= vld_pipe[STAGES-1:0];
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    sprite_hit #(
      .PIX_W(PIX_W), .SPR_W(SPR_W), .SPR_H(SPR_H), .AW(SPR_AW)
    ) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_sh[i]),
      .x       (x_sh[i]),
      .y       (y_sh[i]),
      .hor_pix (hor_pix),
      .ver_pix (ver_pix),
      .hit     (hit0[i]),
      .addr    (spr_addr_a[i])
    );
  end

  // Lowest index opaque sprite wins, then background, then black
  always_comb begin
    pix_nxt = BLACK;
    found   = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && hit1[i] && is_opaque(sdata[i], KEY_COLOR)) begin
        pix_nxt = sdata[i];
        found   = 1'b1;
      end
    end
    if (!found && bg_win1) pix_nxt = bg_data;
    if (!vld_pipe[STAGES]) pix_nxt = BLACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_rgb <= BLACK;
    else        pix_rgb <= pix_nxt;
  end

`ifdef SCROLL_COMPOSITOR_COLLISION_EN
  logic [NUM_SPRITES-1:0] col_set;

  always_comb begin
    col_set = '0;
    for (int i = 1; i < NUM_SPRITES; i++) begin
      col_set[i] = vld_pipe[STAGES] && hit1[0] && hit1[i]
                && is_opaque(sdata[0], KEY_COLOR) && is_opaque(sdata[i], KEY_COLOR);
    end
  end

  // A new overlap outranks a clear arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collide <= '0;
    else        collide <= (clr_collide ? '0 : collide) | col_set;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_collide;
  assign collide    = '0;
`endif
endmodule
